// File: rtl/fft_pingpong_input_buffer.sv
// Ping-pong complex frame buffer feeding the FFT core.
// One bank fills from the stream while the other replays, natural or bit-reversed.
module fft_pingpong_input_buffer #(
  parameter int N     = 16,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  input  logic                    bitrev_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [$clog2(N)-1:0]    out_idx,
  output logic                    out_last
);

  localparam int ADDR_W = $clog2(N);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  function automatic logic [ADDR_W-1:0] f_bitrev(
    input logic [ADDR_W-1:0] a
  );
    for (int i = 0; i < ADDR_W; i++)
      f_bitrev[i] = a[ADDR_W-1-i];
  endfunction

  logic signed [WIDTH-1:0] r_mem_re [2][N];
  logic signed [WIDTH-1:0] r_mem_im [2][N];

  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic              r_mode;

  logic              w_wr_fire;
  logic              w_wr_last;
  logic              w_rd_fire;
  logic              w_rd_last;
  logic              w_rd_order;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [1:0]        w_full_nxt;

  assign in_ready  = !r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];

  assign w_wr_fire = in_valid && in_ready;
  assign w_wr_last = w_wr_fire && (r_wr_cnt == LAST);
  assign w_rd_fire = out_valid && out_ready;
  assign w_rd_last = w_rd_fire && (r_rd_cnt == LAST);

  // Order is sampled on a frame's first beat and held for the rest.
  assign w_rd_order = (r_rd_cnt == '0) ? bitrev_en : r_mode;
  assign w_rd_addr  = w_rd_order ? f_bitrev(r_rd_cnt) : r_rd_cnt;

  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_last)
      w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_last)
      w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire && !flush) begin
      r_mem_re[r_wr_bank][r_wr_cnt] <= in_re;
      r_mem_im[r_wr_bank][r_wr_cnt] <= in_im;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
      r_mode    <= 1'b0;
    end else if (flush) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
      r_mode    <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_fire) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_last)
          r_wr_bank <= !r_wr_bank;
      end
      if (w_rd_fire) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
        if (r_rd_cnt == '0)
          r_mode <= bitrev_en;
        if (w_rd_last)
          r_rd_bank <= !r_rd_bank;
      end
    end
  end

  always_comb begin
    out_re   = '0;
    out_im   = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_re   = r_mem_re[r_rd_bank][w_rd_addr];
      out_im   = r_mem_im[r_rd_bank][w_rd_addr];
      out_idx  = w_rd_addr;
      out_last = (r_rd_cnt == LAST);
    end
  end

endmodule

// File: tb/tb_fft_pingpong_input_buffer.sv
// Directed bench for the ping-pong FFT input buffer.
// Frame table plus hand-written backpressure, flush and reset sequences.
module tb_fft_pingpong_input_buffer;

  localparam int N = 16;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic bitrev_en = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic [3:0] out_idx;
  logic out_last;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_pingpong_input_buffer #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im),
    .bitrev_en(bitrev_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last)
  );

  // ord: nibble j = expected out_idx on read beat j
  // tog: beat at which bitrev_en flips mid-frame (-1 = never)
  typedef struct packed {
    logic        brev;
    logic [31:0] base;
    logic [63:0] ord;
    logic [31:0] tog;
  } vec_t;

  localparam logic [63:0] NAT = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] BRV = 64'hF7B3_D591_E6A2_C480;

  vec_t vecs [4];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic write_frame(input int base);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_re = W'(base + k);
      in_im = W'(-(base + k));
      @(negedge clk);
      chk("wr_in_ready", 64'(in_ready), 64'd1);
      chk("wr_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic read_frame(input vec_t v, input int nb);
    int idx;
    for (int j = 0; j < nb; j++) begin
      if (j == int'(v.tog))
        bitrev_en = !v.brev;
      idx = int'(v.ord[j*4 +: 4]);
      @(negedge clk);
      chk("rd_valid", 64'(out_valid), 64'd1);
      chk("rd_re", 64'(16'(out_re)),
          64'(16'(int'(v.base) + idx)));
      chk("rd_im", 64'(16'(out_im)),
          64'(16'(-(int'(v.base) + idx))));
      chk("rd_idx", 64'(out_idx), 64'(idx));
      chk("rd_last", 64'(out_last), 64'(j == N - 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    out_ready = 1'b1;
    bitrev_en = v.brev;
    write_frame(int'(v.base));
    chk("lat_valid", 64'(out_valid), 64'd1);
    read_frame(v, N);
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_last", 64'(out_last), 64'd0);
  endtask

  int acc;
  int rd_exp;
  logic w_in;
  logic w_out;
  int pb;

  initial begin
    vecs[0] = '{brev: 1'b0, base: 32'd0, ord: NAT, tog: '1};
    vecs[1] = '{brev: 1'b1, base: 32'd0, ord: BRV, tog: '1};
    vecs[2] = '{brev: 1'b0, base: 32'd300, ord: NAT, tog: 32'd5};
    vecs[3] = '{brev: 1'b1, base: 32'd400, ord: BRV, tog: '1};

    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_re", 64'(16'(out_re)), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 4; i++)
      run_vec(vecs[i]);

    // Backpressure: both banks fill, then drain in order.
    bitrev_en = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    rd_exp = 0;
    for (int c = 0; c < 240; c++) begin
      if (c == 40)
        out_ready = 1'b1;
      if (c >= 40 && acc == 40 && rd_exp == 32)
        break;
      in_valid = (acc < 40);
      in_re = W'(acc);
      in_im = W'(-acc);
      @(negedge clk);
      if (c == 39) begin
        chk("bp_stall_acc", 64'(acc), 64'd32);
        chk("bp_stall_rdy", 64'(in_ready), 64'd0);
        chk("bp_stall_vld", 64'(out_valid), 64'd1);
      end
      w_in = in_valid && in_ready;
      w_out = out_valid && out_ready;
      if (w_in && acc == 32)
        chk("bp_resume", 64'(rd_exp >= 16), 64'd1);
      if (w_out) begin
        chk("bp_re", 64'(16'(out_re)), 64'(16'(rd_exp)));
        chk("bp_idx", 64'(out_idx), 64'(rd_exp % 16));
        chk("bp_last", 64'(out_last),
            64'(rd_exp % 16 == 15));
        rd_exp++;
      end
      @(posedge clk);
      #1;
      if (w_in)
        acc++;
    end
    in_valid = 1'b0;
    chk("bp_acc", 64'(acc), 64'd40);
    chk("bp_rd", 64'(rd_exp), 64'd32);
    chk("bp_partial", 64'(out_valid), 64'd0);

    // Flush: drop leftovers, then drop a 7-sample partial.
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_rdy", 64'(in_ready), 64'd1);
    chk("fl_vld", 64'(out_valid), 64'd0);
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_re = W'(50 + k);
      in_im = W'(-(50 + k));
      @(posedge clk);
      #1;
    end
    in_re = W'(999);
    in_im = W'(-999);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_vld2", 64'(out_valid), 64'd0);
    run_vec('{brev: 1'b0, base: 32'd100, ord: NAT, tog: '1});

    // Asynchronous reset during beat 6 of a readout.
    bitrev_en = 1'b0;
    write_frame(500);
    read_frame('{brev: 1'b0, base: 32'd500,
                 ord: NAT, tog: '1}, 6);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_vld", 64'(out_valid), 64'd0);
    chk("ar_rdy", 64'(in_ready), 64'd1);
    chk("ar_re", 64'(16'(out_re)), 64'd0);
    chk("ar_idx", 64'(out_idx), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pb = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid)
        pb++;
    end
    chk("ar_stale", 64'(pb), 64'd0);
    @(posedge clk);
    #1;
    run_vec('{brev: 1'b1, base: 32'd700, ord: BRV, tog: '1});

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
